// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signal bundle for apb_master_arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface apb_master_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ*32-1:0] REQ_ADDR;
  logic [NREQ-1:0]    REQ_WRITE;
  logic [NREQ*32-1:0] REQ_WDATA;
  logic [NREQ-1:0]    REQ_DONE;
  logic [31:0]        RESP_RDATA;
  logic               RESP_ERR;
  logic [NREQ-1:0]    GRANT;
  logic               TIMEOUT_ERR;
  logic               PSEL;
  logic [31:0]        PADDR;
  logic               PWRITE;
  logic               PENABLE;
  logic [31:0]        PWDATA;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    input  REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    output REQ_DONE, RESP_RDATA, RESP_ERR, GRANT, TIMEOUT_ERR,
           PSEL, PADDR, PWRITE, PENABLE, PWDATA
  );

  modport slave (
    output REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    input  REQ_DONE, RESP_RDATA, RESP_ERR, GRANT, TIMEOUT_ERR,
           PSEL, PADDR, PWRITE, PENABLE, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters,
// with a per-transfer PREADY watchdog. All outputs are registered.
module apb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256,
  parameter int TOW     = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TOW-1:0] WD_LAST = TOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [TOW-1:0]  wd_cnt;
  logic            req_any;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_nxt;
  logic [PW:0]     sum;

  // Scan downward so the lowest offset from the pointer is the last assignment.
  always_comb begin
    win     = ptr;
    req_any = 1'b0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (bus.REQ_VALID[sum[PW-1:0]]) begin
        win     = sum[PW-1:0];
        req_any = 1'b1;
      end
    end
    ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state           <= IDLE;
      ptr             <= '0;
      wd_cnt          <= '0;
      bus.REQ_DONE    <= '0;
      bus.RESP_RDATA  <= '0;
      bus.RESP_ERR    <= 1'b0;
      bus.GRANT       <= '0;
      bus.TIMEOUT_ERR <= 1'b0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWRITE      <= 1'b0;
      bus.PWDATA      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            bus.GRANT  <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            bus.PADDR  <= bus.REQ_ADDR[32*win +: 32];
            bus.PWDATA <= bus.REQ_WDATA[32*win +: 32];
            bus.PWRITE <= bus.REQ_WRITE[win];
            bus.PSEL   <= 1'b1;
            ptr        <= ptr_nxt;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          wd_cnt      <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            bus.RESP_RDATA <= bus.PRDATA;
            bus.RESP_ERR   <= bus.PSLVERR;
            bus.REQ_DONE   <= bus.GRANT;
            bus.PSEL       <= 1'b0;
            bus.PENABLE    <= 1'b0;
            bus.PADDR      <= '0;
            bus.PWDATA     <= '0;
            bus.PWRITE     <= 1'b0;
            state          <= DONE;
          end else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
            bus.RESP_RDATA  <= '0;
            bus.RESP_ERR    <= 1'b1;
            bus.TIMEOUT_ERR <= 1'b1;
            bus.REQ_DONE    <= bus.GRANT;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.PADDR       <= '0;
            bus.PWDATA      <= '0;
            bus.PWRITE      <= 1'b0;
            state           <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
          // Spare IDLE cycle follows so requesters can drop REQ_VALID first.
          bus.REQ_DONE    <= '0;
          bus.RESP_RDATA  <= '0;
          bus.RESP_ERR    <= 1'b0;
          bus.TIMEOUT_ERR <= 1'b0;
          bus.GRANT       <= '0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: NREQ=4, TIMEOUT=8.
module tb_apb_master_arbiter;
  localparam int NREQ = 4;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;

  apb_master_arbiter_if #(.NREQ(NREQ)) bus();

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(8), .TOW(16)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus.master)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic w);
    bus.REQ_ADDR[32*i +: 32]  = a;
    bus.REQ_WDATA[32*i +: 32] = d;
    bus.REQ_WRITE[i]          = w;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.RESP_ERR, bus.TIMEOUT_ERR}, 32'd0);
    chk({tag, "_grant_done"}, {24'd0, bus.GRANT, bus.REQ_DONE}, 32'd0);
    chk({tag, "_paddr"}, bus.PADDR, 32'd0);
    chk({tag, "_pwdata"}, bus.PWDATA, 32'd0);
    chk({tag, "_rdata"}, bus.RESP_RDATA, 32'd0);
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int n;
    bus.REQ_VALID = '0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WRITE = '0;
    bus.REQ_WDATA = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;
    tick;
    tick;
    chk_zero("rst");

    // single write, zero wait states
    PRESET = 1'b0;
    set_req(1, 32'h0100_0010, 32'hDEAD_BEEF, 1'b1);
    bus.REQ_VALID = 4'b0010;
    tick;
    chk("w_psel", bus.PSEL, 1);
    chk("w_pen", bus.PENABLE, 0);
    chk("w_grant", bus.GRANT, 4'b0010);
    chk("w_paddr", bus.PADDR, 32'h0100_0010);
    chk("w_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    chk("w_pwrite", bus.PWRITE, 1);
    tick;
    chk("w_pen2", bus.PENABLE, 1);
    chk("w_psel2", bus.PSEL, 1);
    chk("w_done_early", bus.REQ_DONE, 0);
    tick;
    chk("w_done", bus.REQ_DONE, 4'b0010);
    chk("w_err", bus.RESP_ERR, 0);
    chk("w_toerr", bus.TIMEOUT_ERR, 0);
    chk("w_psel_off", bus.PSEL, 0);
    chk("w_paddr_off", bus.PADDR, 0);
    bus.REQ_VALID = '0;
    tick;
    chk("w_done_clr", bus.REQ_DONE, 0);
    chk("w_grant_clr", bus.GRANT, 0);
    tick;
    chk("w_no_regrant", bus.PSEL, 0);

    // read with 3 wait states
    set_req(0, 32'h0000_0200, 32'd0, 1'b0);
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'h1234_5678;
    bus.REQ_VALID = 4'b0001;
    tick;
    chk("r_psel", bus.PSEL, 1);
    chk("r_pwrite", bus.PWRITE, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("r_paddr%0d", i), bus.PADDR, 32'h0000_0200);
      chk($sformatf("r_pen%0d", i), bus.PENABLE, 1);
      if (i == 3) bus.PREADY = 1'b1;
      tick;
    end
    chk("r_done", bus.REQ_DONE, 4'b0001);
    chk("r_rdata", bus.RESP_RDATA, 32'h1234_5678);
    chk("r_err", bus.RESP_ERR, 0);
    bus.REQ_VALID = '0;
    tick;
    chk("r_rdata_clr", bus.RESP_RDATA, 0);

    // slave error
    set_req(2, 32'h0000_0300, 32'd0, 1'b0);
    bus.PSLVERR   = 1'b1;
    bus.PRDATA    = 32'hCAFE_F00D;
    bus.REQ_VALID = 4'b0100;
    tick;
    tick;
    tick;
    chk("e_done", bus.REQ_DONE, 4'b0100);
    chk("e_err", bus.RESP_ERR, 1);
    chk("e_toerr", bus.TIMEOUT_ERR, 0);
    chk("e_rdata", bus.RESP_RDATA, 32'hCAFE_F00D);
    bus.REQ_VALID = '0;
    bus.PSLVERR   = 1'b0;
    tick;

    // watchdog abort after 8 ACCESS cycles
    set_req(3, 32'h0000_0400, 32'h0BAD_0BAD, 1'b1);
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'hFFFF_FFFF;
    bus.REQ_VALID = 4'b1000;
    tick;
    tick;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("wd_pen%0d", i), bus.PENABLE, 1);
      tick;
    end
    chk("wd_psel8", bus.PSEL, 1);
    chk("wd_done8_early", bus.REQ_DONE, 0);
    tick;
    chk("wd_psel_off", bus.PSEL, 0);
    chk("wd_pen_off", bus.PENABLE, 0);
    chk("wd_err", bus.RESP_ERR, 1);
    chk("wd_toerr", bus.TIMEOUT_ERR, 1);
    chk("wd_rdata", bus.RESP_RDATA, 0);
    chk("wd_done", bus.REQ_DONE, 4'b1000);
    chk("wd_paddr", bus.PADDR, 0);
    bus.REQ_VALID = '0;
    tick;
    chk("wd_toerr_clr", bus.TIMEOUT_ERR, 0);

    // PREADY in the threshold cycle wins
    set_req(0, 32'h0000_0500, 32'd0, 1'b0);
    bus.PRDATA    = 32'h55AA_55AA;
    bus.REQ_VALID = 4'b0001;
    tick;
    tick;
    repeat (7) tick;
    chk("th_pen8", bus.PENABLE, 1);
    bus.PREADY = 1'b1;
    tick;
    chk("th_done", bus.REQ_DONE, 4'b0001);
    chk("th_toerr", bus.TIMEOUT_ERR, 0);
    chk("th_err", bus.RESP_ERR, 0);
    chk("th_rdata", bus.RESP_RDATA, 32'h55AA_55AA);
    bus.REQ_VALID = '0;
    tick;

    // reset during ACCESS, then all four contend
    set_req(2, 32'h0000_0600, 32'd0, 1'b0);
    bus.PREADY    = 1'b0;
    bus.REQ_VALID = 4'b0100;
    tick;
    tick;
    chk("mr_pen", bus.PENABLE, 1);
    PRESET = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, 32'h1000_0000 + 32'(16 * k), 32'h0000_00A0 + 32'(k), 1'b1);
    bus.REQ_VALID = 4'b1111;
    tick;
    chk_zero("mr");
    PRESET     = 1'b0;
    bus.PREADY = 1'b1;

    // round-robin order 0,1,2,3 then 0 again
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (bus.GRANT == '0 && n < 20) begin
        tick;
        n++;
      end
      chk($sformatf("rr_grant%0d", j), bus.GRANT, 32'(1 << order[j]));
      chk($sformatf("rr_paddr%0d", j), bus.PADDR, 32'h1000_0000 + 32'(16 * order[j]));
      n = 0;
      while (bus.REQ_DONE == '0 && n < 20) begin
        tick;
        n++;
      end
      chk($sformatf("rr_done%0d", j), bus.REQ_DONE, 32'(1 << order[j]));
      bus.REQ_VALID[order[j]] = 1'b0;
      if (j == 1) bus.REQ_VALID[0] = 1'b1;
      tick;
    end
    tick;
    chk("rr_idle", bus.PSEL, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
